// File: rtl/eq_chk_pkg.sv
// Shared definitions for the stream equivalence checker: FSM state
// encoding, default parameter values and FIFO pointer sizing.
package eq_chk_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_DRAIN_CYC = 10;
  localparam int DEF_CNT_W     = 16;

  // Address bits needed to index DEPTH entries; the FIFO adds one wrap bit.
  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/eq_sync_fifo.sv
// Synchronous first-word-fall-through FIFO. Pointers carry one extra MSB so
// full and empty are distinguishable when the address bits are equal.
// Push while full is only accepted together with a pop (occupancy unchanged).
module eq_sync_fifo
  import eq_chk_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = fifo_ptr_w(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  // Pointer update; clr empties the FIFO at the start of a new window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; a full push+pop overwrites the slot being read out now.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/eq_stream_checker.sv
// Equivalence checker for two AXI-stream producers (A: ILA model, B: HLS RTL).
// Beats from each side are buffered in their own FIFO and compared in order.
// Optional macro EQ_STREAM_CHECKER_TLAST_EN adds tlast to each beat.
//
// Handshake: a beat is taken from a side only in a cycle where its tvalid,
// the shared sink_tready and that side's step enable are all high; there is
// no back-pressure to the designs other than withholding the step enable.
module eq_stream_checker
  import eq_chk_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int DRAIN_CYC = DEF_DRAIN_CYC,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a_complete,
  input  logic              b_complete,
  input  logic              sink_tready,
  input  logic [DATA_W-1:0] a_tdata,
  input  logic              a_tvalid,
  input  logic [DATA_W-1:0] b_tdata,
  input  logic              b_tvalid,
  output logic              a_step,
  output logic              b_step,
  output logic              done,
  output logic              pass,
  output logic              mismatch,
  output logic              overflow,
  output logic [CNT_W-1:0]  beat_cnt,
  output logic [DATA_W-1:0] mis_a_data,
  output logic [DATA_W-1:0] mis_b_data,
`ifdef EQ_STREAM_CHECKER_TLAST_EN
  input  logic              a_tlast,
  input  logic              b_tlast,
  output logic [1:0]        mis_tlast,
`endif
  output logic [2:0]        state_dbg
);

`ifdef EQ_STREAM_CHECKER_TLAST_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif
  localparam int DCW = $clog2(DRAIN_CYC + 2);
  localparam logic [DCW-1:0] DRAIN_LIM = DCW'(DRAIN_CYC);

  state_e         state;
  logic [DCW-1:0] drain_cnt;
  logic [FW-1:0]  a_beat, b_beat, a_head, b_head, cmp_a, cmp_b;
  logic           a_empty, a_full, b_empty, b_full;
  logic           push_a, push_b, pop_both, clr, active;
  logic           cmp_valid, cmp_bad, ovf_now, one_sided;

`ifdef EQ_STREAM_CHECKER_TLAST_EN
  assign a_beat = {a_tlast, a_tdata};
  assign b_beat = {b_tlast, b_tdata};
`else
  assign a_beat = a_tdata;
  assign b_beat = b_tdata;
`endif

  assign state_dbg = state;
  assign active    = (state == ST_RUN) || (state == ST_DRAIN);
  assign a_step    = (state == ST_RUN) && !a_complete;
  assign b_step    = (state == ST_RUN) && (drain_cnt <= DRAIN_LIM);
  assign push_a    = (state == ST_RUN) && a_tvalid && sink_tready && a_step;
  assign push_b    = (state == ST_RUN) && b_tvalid && sink_tready && b_step;
  assign pop_both  = active && !a_empty && !b_empty;
  assign clr       = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_FAIL));
  assign ovf_now   = ((push_a && a_full) || (push_b && b_full)) && !pop_both;
  assign cmp_bad   = active && cmp_valid && (cmp_a != cmp_b);
  assign one_sided = (state == ST_DRAIN) && (a_empty != b_empty);

  eq_sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .clr(clr), .push(push_a), .pop(pop_both),
    .din(a_beat), .dout(a_head), .empty(a_empty), .full(a_full)
  );

  eq_sync_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .clr(clr), .push(push_b), .pop(pop_both),
    .din(b_beat), .dout(b_head), .empty(b_empty), .full(b_full)
  );

  // Control FSM, registered compare stage, verdict flags and mismatch capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      drain_cnt  <= '0;
      cmp_valid  <= 1'b0;
      cmp_a      <= '0;
      cmp_b      <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      overflow   <= 1'b0;
      beat_cnt   <= '0;
      mis_a_data <= '0;
      mis_b_data <= '0;
`ifdef EQ_STREAM_CHECKER_TLAST_EN
      mis_tlast  <= '0;
`endif
    end else if (clr) begin
      state      <= ST_RUN;
      drain_cnt  <= '0;
      cmp_valid  <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      overflow   <= 1'b0;
      beat_cnt   <= '0;
      mis_a_data <= '0;
      mis_b_data <= '0;
`ifdef EQ_STREAM_CHECKER_TLAST_EN
      mis_tlast  <= '0;
`endif
    end else begin
      cmp_valid <= pop_both;
      cmp_a     <= a_head;
      cmp_b     <= b_head;

      // Drain counter counts consecutive b_complete cycles, holding once past the limit.
      if (state == ST_RUN) begin
        if (!b_complete)                drain_cnt <= '0;
        else if (drain_cnt <= DRAIN_LIM) drain_cnt <= drain_cnt + 1'b1;
      end

      if (active && cmp_valid && !cmp_bad && (beat_cnt != '1))
        beat_cnt <= beat_cnt + 1'b1;

      if (cmp_bad && !mismatch) begin
        mismatch   <= 1'b1;
        mis_a_data <= cmp_a[DATA_W-1:0];
        mis_b_data <= cmp_b[DATA_W-1:0];
`ifdef EQ_STREAM_CHECKER_TLAST_EN
        mis_tlast  <= {cmp_a[DATA_W], cmp_b[DATA_W]};
`endif
      end else if (one_sided && !mismatch) begin
        mismatch   <= 1'b1;
        mis_a_data <= a_empty ? '0 : a_head[DATA_W-1:0];
        mis_b_data <= b_empty ? '0 : b_head[DATA_W-1:0];
`ifdef EQ_STREAM_CHECKER_TLAST_EN
        mis_tlast  <= {(a_empty ? 1'b0 : a_head[DATA_W]), (b_empty ? 1'b0 : b_head[DATA_W])};
`endif
      end

      if (ovf_now) overflow <= 1'b1;

      if (active && (cmp_bad || ovf_now || one_sided)) begin
        state <= ST_FAIL;
        done  <= 1'b1;
      end else if ((state == ST_RUN) && a_complete && (drain_cnt > DRAIN_LIM)) begin
        state <= ST_DRAIN;
      end else if ((state == ST_DRAIN) && a_empty && b_empty) begin
        state <= ST_DONE;
        done  <= 1'b1;
        pass  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eq_stream_checker.sv
// Directed bench for eq_stream_checker: one task per scenario, inline checks.
module tb_eq_stream_checker;

  localparam int DATA_W = 8;
  localparam int DEPTH = 16;
  localparam int DRAIN_CYC = 10;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst, start, a_complete, b_complete, sink_tready;
  logic [DATA_W-1:0] a_tdata, b_tdata;
  logic              a_tvalid, b_tvalid;
  logic              a_step, b_step, done, pass, mismatch, overflow;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] mis_a_data, mis_b_data;
  logic [2:0]        state_dbg;
`ifdef EQ_STREAM_CHECKER_TLAST_EN
  logic              a_tlast, b_tlast;
  logic [1:0]        mis_tlast;
`endif

  int vectors = 0;
  int miscompares = 0;

  eq_stream_checker #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DRAIN_CYC(DRAIN_CYC), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .a_complete(a_complete), .b_complete(b_complete),
    .sink_tready(sink_tready), .a_tdata(a_tdata), .a_tvalid(a_tvalid),
    .b_tdata(b_tdata), .b_tvalid(b_tvalid), .a_step(a_step), .b_step(b_step),
    .done(done), .pass(pass), .mismatch(mismatch), .overflow(overflow),
    .beat_cnt(beat_cnt), .mis_a_data(mis_a_data), .mis_b_data(mis_b_data),
`ifdef EQ_STREAM_CHECKER_TLAST_EN
    .a_tlast(a_tlast), .b_tlast(b_tlast), .mis_tlast(mis_tlast),
`endif
    .state_dbg(state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; a_complete = 0; b_complete = 0; sink_tready = 1;
    a_tdata = '0; b_tdata = '0; a_tvalid = 0; b_tvalid = 0;
`ifdef EQ_STREAM_CHECKER_TLAST_EN
    a_tlast = 0; b_tlast = 0;
`endif
  endtask

  task automatic do_start();
    start = 1;
    cyc();
    start = 0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        ok = 1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    clear_inputs();
    repeat (2) cyc();
    vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL rst_state got %0d want 0", state_dbg); end
    vectors++; if ({done, pass, mismatch, overflow} !== 4'b0) begin miscompares++; $display("FAIL rst_flags got %b want 0000", {done, pass, mismatch, overflow}); end
    vectors++; if ({a_step, b_step} !== 2'b00) begin miscompares++; $display("FAIL rst_steps got %b want 00", {a_step, b_step}); end
    vectors++; if (beat_cnt !== '0) begin miscompares++; $display("FAIL rst_beat_cnt got %0d want 0", beat_cnt); end
    rst = 0;
    cyc();
    vectors++; if ({a_step, b_step} !== 2'b00) begin miscompares++; $display("FAIL idle_steps got %b want 00", {a_step, b_step}); end
  endtask

  task automatic test_identical();
    logic [7:0] v [3] = '{8'h11, 8'h22, 8'h33};
    bit ok;
    do_start();
    vectors++; if (state_dbg !== 3'd1) begin miscompares++; $display("FAIL id_run got %0d want 1", state_dbg); end
    for (int i = 0; i < 3; i++) begin
      a_tvalid = 1; b_tvalid = 1; a_tdata = v[i]; b_tdata = v[i];
      start = (i == 1);  // ignored while running
      cyc();
    end
    start = 0; a_tvalid = 0; b_tvalid = 0;
    a_complete = 1; b_complete = 1;
    #1;
    vectors++; if ({a_step, b_step} !== 2'b01) begin miscompares++; $display("FAIL id_steps got %b want 01", {a_step, b_step}); end
    wait_done(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL id_timeout got %b want 1", ok); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL id_pass got %b want 1", pass); end
    vectors++; if (beat_cnt !== 16'd3) begin miscompares++; $display("FAIL id_beat_cnt got %0d want 3", beat_cnt); end
    vectors++; if (state_dbg !== 3'd3) begin miscompares++; $display("FAIL id_state got %0d want 3", state_dbg); end
    vectors++; if (mismatch !== 1'b0) begin miscompares++; $display("FAIL id_mismatch got %b want 0", mismatch); end
    a_complete = 0; b_complete = 0;
  endtask

  task automatic test_b_lag();
    bit ok;
    int cnt;
    do_start();
    for (int i = 0; i < 11; i++) begin
      a_tvalid = (i < 4);
      a_tdata = 8'(8'h41 + i);
      b_tvalid = (i >= 5) && (i < 9);
      b_tdata = 8'(8'h41 + i - 5);
      a_complete = (i >= 4);
      cyc();
    end
    a_tvalid = 0; b_tvalid = 0;
    b_complete = 1;
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (b_step) cnt++;
      else break;
      cyc();
    end
    vectors++; if (cnt !== 11) begin miscompares++; $display("FAIL lag_b_step_cycles got %0d want 11", cnt); end
    wait_done(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL lag_timeout got %b want 1", ok); end
    vectors++; if (pass !== 1'b1) begin miscompares++; $display("FAIL lag_pass got %b want 1", pass); end
    vectors++; if (beat_cnt !== 16'd4) begin miscompares++; $display("FAIL lag_beat_cnt got %0d want 4", beat_cnt); end
    a_complete = 0; b_complete = 0;
  endtask

  task automatic test_mismatch();
    do_start();
    a_tvalid = 1; b_tvalid = 1; a_tdata = 8'h10; b_tdata = 8'h10;
    cyc();
    a_tdata = 8'h20; b_tdata = 8'h21;
    cyc();
    a_tvalid = 0; b_tvalid = 0;
    cyc();
    vectors++; if (mismatch !== 1'b0) begin miscompares++; $display("FAIL mm_early got %b want 0", mismatch); end
    vectors++; if (beat_cnt !== 16'd1) begin miscompares++; $display("FAIL mm_beat_early got %0d want 1", beat_cnt); end
    cyc();
    vectors++; if (mismatch !== 1'b1) begin miscompares++; $display("FAIL mm_flag got %b want 1", mismatch); end
    vectors++; if (mis_a_data !== 8'h20) begin miscompares++; $display("FAIL mm_a_data got %h want 20", mis_a_data); end
    vectors++; if (mis_b_data !== 8'h21) begin miscompares++; $display("FAIL mm_b_data got %h want 21", mis_b_data); end
    vectors++; if (beat_cnt !== 16'd1) begin miscompares++; $display("FAIL mm_beat_cnt got %0d want 1", beat_cnt); end
    vectors++; if ({done, pass} !== 2'b10) begin miscompares++; $display("FAIL mm_verdict got %b want 10", {done, pass}); end
    vectors++; if (state_dbg !== 3'd4) begin miscompares++; $display("FAIL mm_state got %0d want 4", state_dbg); end
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 17; i++) begin
      a_tvalid = 1; a_tdata = 8'(i);
      cyc();
      if (i == 15) begin
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL ovf_full_no_ovf got %b want 0", overflow); end
        vectors++; if (state_dbg !== 3'd1) begin miscompares++; $display("FAIL ovf_full_state got %0d want 1", state_dbg); end
      end
    end
    a_tvalid = 0;
    vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b want 1", overflow); end
    vectors++; if (state_dbg !== 3'd4) begin miscompares++; $display("FAIL ovf_state got %0d want 4", state_dbg); end
    vectors++; if ({done, pass, mismatch} !== 3'b100) begin miscompares++; $display("FAIL ovf_verdict got %b want 100", {done, pass, mismatch}); end
  endtask

  task automatic test_drain_fail();
    bit ok;
    do_start();
    for (int i = 0; i < 3; i++) begin
      a_tvalid = 1; a_tdata = 8'(8'hA1 + i);
      b_tvalid = (i < 2); b_tdata = 8'(8'hA1 + i);
      cyc();
    end
    a_tvalid = 0; b_tvalid = 0;
    a_complete = 1; b_complete = 1;
    wait_done(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL dr_timeout got %b want 1", ok); end
    vectors++; if (mismatch !== 1'b1) begin miscompares++; $display("FAIL dr_mismatch got %b want 1", mismatch); end
    vectors++; if (mis_a_data !== 8'hA3) begin miscompares++; $display("FAIL dr_a_data got %h want a3", mis_a_data); end
    vectors++; if (mis_b_data !== 8'h00) begin miscompares++; $display("FAIL dr_b_data got %h want 00", mis_b_data); end
    vectors++; if (beat_cnt !== 16'd2) begin miscompares++; $display("FAIL dr_beat_cnt got %0d want 2", beat_cnt); end
    vectors++; if ({pass, overflow} !== 2'b00) begin miscompares++; $display("FAIL dr_pass_ovf got %b want 00", {pass, overflow}); end
    vectors++; if (state_dbg !== 3'd4) begin miscompares++; $display("FAIL dr_state got %0d want 4", state_dbg); end
    a_complete = 0; b_complete = 0;
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    do_start();
    for (int i = 0; i < 7; i++) begin
      a_tvalid = 1; a_tdata = (i < 2) ? 8'(8'h51 + i) : 8'(8'h60 + i);
      b_tvalid = (i < 2); b_tdata = 8'(8'h51 + i);
      cyc();
    end
    a_tvalid = 0; b_tvalid = 0;
    repeat (3) cyc();
    vectors++; if (beat_cnt !== 16'd2) begin miscompares++; $display("FAIL mr_pre_beat got %0d want 2", beat_cnt); end
    #2 rst = 1;
    #1;
    vectors++; if ({a_step, b_step, done, pass, mismatch, overflow} !== 6'b0) begin miscompares++; $display("FAIL mr_flags got %b want 000000", {a_step, b_step, done, pass, mismatch, overflow}); end
    vectors++; if (beat_cnt !== '0) begin miscompares++; $display("FAIL mr_beat got %0d want 0", beat_cnt); end
    vectors++; if ({mis_a_data, mis_b_data} !== 16'h0) begin miscompares++; $display("FAIL mr_mis got %h want 0000", {mis_a_data, mis_b_data}); end
    vectors++; if (state_dbg !== 3'd0) begin miscompares++; $display("FAIL mr_state got %0d want 0", state_dbg); end
    cyc();
    rst = 0;
    cyc();
    do_start();
    for (int i = 0; i < 2; i++) begin
      a_tvalid = 1; b_tvalid = 1; a_tdata = 8'(8'h77 + i); b_tdata = 8'(8'h77 + i);
      cyc();
    end
    a_tvalid = 0; b_tvalid = 0;
    a_complete = 1; b_complete = 1;
    wait_done(ok);
    vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL mr_timeout got %b want 1", ok); end
    vectors++; if ({pass, mismatch} !== 2'b10) begin miscompares++; $display("FAIL mr_verdict got %b want 10", {pass, mismatch}); end
    vectors++; if (beat_cnt !== 16'd2) begin miscompares++; $display("FAIL mr_beat_cnt got %0d want 2", beat_cnt); end
    a_complete = 0; b_complete = 0;
  endtask

  initial begin
    test_reset();
    test_identical();
    test_b_lag();
    test_mismatch();
    test_overflow();
    test_drain_fail();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/eq_stream_checker.md
Name: eq_stream_checker

Overview:
- Parametrised successor to the two-design equivalence harness.
- Compares the AXI-stream output beats of design A (ILA model) and design B (HLS RTL) in order.
- Designs may emit beats at different cycles; each side is buffered in its own FIFO.
- Generates per-design step enables, a post-completion drain window for B, and a latched pass/fail verdict with mismatch capture.

Parameters:
- DATA_W, 8, stream data width per beat
- DEPTH, 16, per-side FIFO entries; power of two, >=2
- DRAIN_CYC, 10, cycles B keeps stepping after b_complete
- CNT_W, 16, width of the beat counter

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous active-high reset
- start  in  1  pulse; begins a check window from IDLE
- a_complete  in  1  design A finished its instruction
- b_complete  in  1  design B finished its instruction
- sink_tready  in  1  downstream ready shared by both designs
- a_tdata  in  DATA_W  design A output data
- a_tvalid  in  1  design A output valid
- b_tdata  in  DATA_W  design B output data
- b_tvalid  in  1  design B output valid
- a_step  out  1  clock enable for design A
- b_step  out  1  clock enable for design B
- done  out  1  verdict valid (sticky until start/rst)
- pass  out  1  verdict: streams equal
- mismatch  out  1  data mismatch detected
- overflow  out  1  a FIFO overflowed
- beat_cnt  out  CNT_W  matched beat pairs compared
- mis_a_data  out  DATA_W  A beat at first mismatch
- mis_b_data  out  DATA_W  B beat at first mismatch

Behaviour:
- Reset (async, rst=1): all outputs 0; FIFOs empty; drain counter 0; FSM=IDLE.
- FSM states: IDLE, RUN, DRAIN, DONE, FAIL.
- IDLE:
  - a_step=b_step=0.
  - start -> RUN; clears FIFOs, beat_cnt and all flags.
- RUN:
  - a_step=~a_complete.
  - b_step=1 while drain counter <= DRAIN_CYC.
  - Drain counter increments each cycle b_complete=1; it resets to 0 when b_complete=0.
  - When a_complete & (drain counter > DRAIN_CYC) -> DRAIN.
- DRAIN:
  - a_step=b_step=0; comparison continues.
  - If both FIFOs are empty -> DONE with pass=1.
  - If exactly one FIFO is empty and the other is not -> FAIL with mismatch=1; mis_* captures the head of the non-empty side and 0 for the empty side.
- DONE/FAIL:
  - Terminal; steps 0; done=1.
  - start re-enters RUN.
- Capture:
  - Push into the A FIFO when a_tvalid & sink_tready & a_step; same rule for B.
  - Capture is only enabled in RUN.
- Compare:
  - In RUN or DRAIN, when both FIFOs are non-empty, pop both heads in the same cycle.
  - Registered result, 1-cycle latency: on the next cycle either beat_cnt increments, or mismatch=1, mis_* latched, FSM -> FAIL.
  - Only the first mismatch is captured.
- FIFO boundaries:
  - Push and pop on a full FIFO in the same cycle is legal; occupancy is unchanged.
  - Push on a full FIFO without a pop sets overflow=1, drops the beat, FSM -> FAIL.
  - Pop never occurs on empty.
- Wrap-around:
  - beat_cnt saturates at all-ones.
  - FIFO pointers wrap modulo DEPTH, with an extra MSB used for full/empty.
- Simultaneous events:
  - start while in RUN/DRAIN is ignored.
  - overflow and mismatch in the same cycle set both flags; pass=0.
  - rst at any point aborts immediately to IDLE.

Optional Feature:
- Macro: EQ_STREAM_CHECKER_TLAST_EN.
- When defined:
  - Adds ports a_tlast and b_tlast (in, 1 bit each).
  - FIFO width becomes DATA_W+1; tlast is stored alongside the data and compared as part of each beat.
  - Adds output mis_tlast (2 bits: {A,B}) captured at the first mismatch.
- When undefined: none of these ports exist; behaviour is as above.

Decomposition:
- Package eq_chk_pkg holds:
  - FSM state enum (IDLE=0, RUN=1, DRAIN=2, DONE=3, FAIL=4; 3-bit).
  - Default parameter constants.
  - A function computing the FIFO pointer width from DEPTH.
- Sub-module eq_sync_fifo:
  - Parametrised by width and depth.
  - Signals: push, pop, din, dout (head, first-word fall-through), empty, full.
  - Instantiated once per side.

Test Plan:
- Identical streams 0x11,0x22,0x33 from both sides at the same cycles, then both complete -> done=1, pass=1, beat_cnt=3.
- B lags A by 5 cycles with the same 4 beats; B completes 3 cycles after its last beat -> pass=1, beat_cnt=4, b_step stays 1 for 11 cycles after b_complete.
- A sends 0x10,0x20 and B sends 0x10,0x21 -> mismatch=1 one cycle after the second pop, mis_a_data=0x20, mis_b_data=0x21, beat_cnt=1, pass=0.
- A sends 17 beats while B is silent, DEPTH=16 -> overflow=1 on the 17th push, FSM in FAIL, done=1.
- A sends 3 beats and B sends 2; both complete -> DRAIN ends in FAIL with mismatch=1, mis_b_data=0, beat_cnt=2.
- Assert rst mid-RUN with 5 beats buffered -> all outputs 0 the same cycle; the next start yields a clean run with beat_cnt counting from 0.
